// File: rtl/cpu_result_merge.sv
// cpu_result_merge: per-channel result FIFOs drained by a single arbiter
// into one registered register-file writeback port with backpressure.
module cpu_result_merge #(
    parameter  int NUM_CH  = 3,
    parameter  int DATA_W  = 32,
    parameter  int DEST_W  = 5,
    parameter  int DEPTH   = 4,
    parameter  int RR_MODE = 1,
    localparam int CH_W    = $clog2(NUM_CH),
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         src_valid,
    input  logic [NUM_CH*DATA_W-1:0]  src_data,
    input  logic [NUM_CH*DEST_W-1:0]  src_dest,
    output logic [NUM_CH-1:0]         src_ready,
    input  logic                      wb_ready,
    output logic                      wb_valid,
    output logic [DEST_W-1:0]         wb_dest,
    output logic [DATA_W-1:0]         wb_data,
    output logic [CH_W-1:0]           wb_ch,
    output logic [NUM_CH-1:0]         overflow,
    input  logic                      overflow_clr,
    output logic [NUM_CH*CNT_W-1:0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = DEST_W + DATA_W;

    // FIFO storage and bookkeeping
    logic [ENT_W-1:0]  mem_q    [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];

    // Registered status
    logic [NUM_CH-1:0] src_ready_q;
    logic [NUM_CH-1:0] src_ready_d;
    logic [NUM_CH-1:0] overflow_q;
    logic [NUM_CH-1:0] overflow_d;

    // Writeback register
    logic              wb_valid_q;
    logic              wb_valid_d;
    logic [DEST_W-1:0] wb_dest_q;
    logic [DEST_W-1:0] wb_dest_d;
    logic [DATA_W-1:0] wb_data_q;
    logic [DATA_W-1:0] wb_data_d;
    logic [CH_W-1:0]   wb_ch_q;
    logic [CH_W-1:0]   wb_ch_d;

    // Round-robin pointer: last granted channel
    logic [CH_W-1:0]   rr_ptr_q;
    logic [CH_W-1:0]   rr_ptr_d;

    // Per-cycle control
    logic [NUM_CH-1:0] nonempty;
    logic [NUM_CH-1:0] want;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] ovf_evt;
    logic              load;
    logic              gnt_found;
    logic [CH_W-1:0]   gnt_idx;
    logic [CH_W-1:0]   cand;
    logic [ENT_W-1:0]  head;

    // Channel has at least one buffered entry
    always_comb begin
        nonempty = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            nonempty[i] = (cnt_q[i] != '0);
        end
    end

    // Grant selection; scanned backwards so the earliest candidate wins
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        if (RR_MODE != 0) begin
            for (int off = NUM_CH; off >= 1; off--) begin
                cand = CH_W'((int'(rr_ptr_q) + off) % NUM_CH);
                if (nonempty[cand]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end else begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (nonempty[i]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = CH_W'(i);
                end
            end
        end
    end

    // Output register load and pop of the granted FIFO head
    always_comb begin
        load       = !wb_valid_q || wb_ready;
        pop        = '0;
        wb_valid_d = wb_valid_q;
        wb_dest_d  = wb_dest_q;
        wb_data_d  = wb_data_q;
        wb_ch_d    = wb_ch_q;
        rr_ptr_d   = rr_ptr_q;
        head       = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
        if (load) begin
            wb_valid_d = gnt_found;
            if (gnt_found) begin
                pop[gnt_idx] = 1'b1;
                wb_dest_d    = head[ENT_W-1 -: DEST_W];
                wb_data_d    = head[DATA_W-1:0];
                wb_ch_d      = gnt_idx;
                if (RR_MODE != 0) begin
                    rr_ptr_d = gnt_idx;
                end
            end
        end
    end

    // Push/drop decisions; a same-cycle pop frees a slot in a full FIFO
    always_comb begin
        want        = '0;
        full        = '0;
        push        = '0;
        ovf_evt     = '0;
        src_ready_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            want[i]     = src_valid[i] &&
                          (src_dest[i*DEST_W +: DEST_W] != '0);
            full[i]     = (cnt_q[i] == CNT_W'(DEPTH));
            push[i]     = want[i] && (!full[i] || pop[i]);
            ovf_evt[i]  = want[i] && full[i] && !pop[i];
            cnt_d[i]    = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PTR_W'(1) : wr_ptr_q[i];
            rd_ptr_d[i] = pop[i] ? rd_ptr_q[i] + PTR_W'(1) : rd_ptr_q[i];
            src_ready_d[i] = (cnt_d[i] < CNT_W'(DEPTH));
        end
        overflow_d = (overflow_clr ? '0 : overflow_q) | ovf_evt;
    end

    // FIFO payload storage; contents are don't-care while empty
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <=
                    {src_dest[i*DEST_W +: DEST_W],
                     src_data[i*DATA_W +: DATA_W]};
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            src_ready_q <= '1;
            overflow_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_dest_q   <= '0;
            wb_data_q   <= '0;
            wb_ch_q     <= '0;
            rr_ptr_q    <= CH_W'(NUM_CH - 1);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            src_ready_q <= src_ready_d;
            overflow_q  <= overflow_d;
            wb_valid_q  <= wb_valid_d;
            wb_dest_q   <= wb_dest_d;
            wb_data_q   <= wb_data_d;
            wb_ch_q     <= wb_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Pack the per-channel counters onto the occupancy bus
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            occupancy[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign src_ready = src_ready_q;
    assign overflow  = overflow_q;
    assign wb_valid  = wb_valid_q;
    assign wb_dest   = wb_dest_q;
    assign wb_data   = wb_data_q;
    assign wb_ch     = wb_ch_q;

endmodule

// File: tb/tb_cpu_result_merge.sv
// tb_cpu_result_merge: round-robin and fixed-priority instances share
// stimulus and are compared each cycle against queue-based models.
module tb_cpu_result_merge;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 4;
    localparam int CW = 2;
    localparam int OW = 3;
    localparam int EW = AW + DW;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]    src_valid = '0;
    logic [N*DW-1:0] src_data  = '0;
    logic [N*AW-1:0] src_dest  = '0;
    logic          wb_ready = 1'b1;
    logic          overflow_clr = 1'b0;

    logic [N-1:0]    rdy_o  [2];
    logic            vld_o  [2];
    logic [AW-1:0]   dest_o [2];
    logic [DW-1:0]   data_o [2];
    logic [CW-1:0]   ch_o   [2];
    logic [N-1:0]    ovf_o  [2];
    logic [N*OW-1:0] occ_o  [2];

    int total  = 0;
    int passed = 0;

    // model state: index 0 round-robin, 1 fixed priority
    logic [EW-1:0] mq [2*N][$];
    bit            mv   [2];
    logic [AW-1:0] md   [2];
    logic [DW-1:0] mdat [2];
    int            mch  [2];
    int            mptr [2];
    logic [N-1:0]  movf [2];

    logic [AW-1:0] got [$];

    always #5 clock = ~clock;

    cpu_result_merge #(
        .NUM_CH(N), .DATA_W(DW), .DEST_W(AW), .DEPTH(D), .RR_MODE(1)
    ) dut_rr (
        .clock(clock), .reset(reset),
        .src_valid(src_valid), .src_data(src_data), .src_dest(src_dest),
        .src_ready(rdy_o[0]), .wb_ready(wb_ready),
        .wb_valid(vld_o[0]), .wb_dest(dest_o[0]), .wb_data(data_o[0]),
        .wb_ch(ch_o[0]), .overflow(ovf_o[0]),
        .overflow_clr(overflow_clr), .occupancy(occ_o[0])
    );

    cpu_result_merge #(
        .NUM_CH(N), .DATA_W(DW), .DEST_W(AW), .DEPTH(D), .RR_MODE(0)
    ) dut_fp (
        .clock(clock), .reset(reset),
        .src_valid(src_valid), .src_data(src_data), .src_dest(src_dest),
        .src_ready(rdy_o[1]), .wb_ready(wb_ready),
        .wb_valid(vld_o[1]), .wb_dest(dest_o[1]), .wb_data(data_o[1]),
        .wb_ch(ch_o[1]), .overflow(ovf_o[1]),
        .overflow_clr(overflow_clr), .occupancy(occ_o[1])
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2*N; k++) mq[k].delete();
        for (int m = 0; m < 2; m++) begin
            mv[m] = 0; md[m] = '0; mdat[m] = '0;
            mch[m] = 0; mptr[m] = N - 1; movf[m] = '0;
        end
    endtask

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            int g;
            bit ld;
            logic [EW-1:0] e;
            logic [AW-1:0] dd;
            ld = !mv[m] || wb_ready;
            g = -1;
            if (ld) begin
                if (m == 0) begin
                    for (int k = 1; k <= N; k++) begin
                        int c = (mptr[m] + k) % N;
                        if (g < 0 && mq[m*N+c].size() > 0) g = c;
                    end
                end else begin
                    for (int c = N - 1; c >= 0; c--)
                        if (mq[m*N+c].size() > 0) g = c;
                end
            end
            if (g >= 0) begin
                e = mq[m*N+g].pop_front();
                mv[m] = 1; md[m] = e[EW-1:DW]; mdat[m] = e[DW-1:0];
                mch[m] = g;
                if (m == 0) mptr[m] = g;
            end else if (ld) begin
                mv[m] = 0;
            end
            if (overflow_clr) movf[m] = '0;
            for (int c = 0; c < N; c++) begin
                dd = src_dest[c*AW +: AW];
                if (src_valid[c] && dd != 0) begin
                    if (mq[m*N+c].size() < D)
                        mq[m*N+c].push_back({dd, src_data[c*DW +: DW]});
                    else
                        movf[m][c] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            logic [N*OW-1:0] eocc;
            logic [N-1:0] erdy;
            eocc = '0;
            erdy = '0;
            for (int c = 0; c < N; c++) begin
                eocc[c*OW +: OW] = OW'(mq[m*N+c].size());
                erdy[c] = (mq[m*N+c].size() < D);
            end
            chk($sformatf("m%0d.wb_valid", m), 64'(vld_o[m]), 64'(mv[m]));
            if (mv[m]) begin
                chk($sformatf("m%0d.wb_dest", m), 64'(dest_o[m]), 64'(md[m]));
                chk($sformatf("m%0d.wb_data", m), 64'(data_o[m]), 64'(mdat[m]));
                chk($sformatf("m%0d.wb_ch", m), 64'(ch_o[m]), 64'(mch[m]));
            end
            chk($sformatf("m%0d.src_ready", m), 64'(rdy_o[m]), 64'(erdy));
            chk($sformatf("m%0d.overflow", m), 64'(ovf_o[m]), 64'(movf[m]));
            chk($sformatf("m%0d.occupancy", m), 64'(occ_o[m]), 64'(eocc));
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic put(int c, logic [AW-1:0] d, logic [DW-1:0] v);
        src_valid[c] = 1'b1;
        src_dest[c*AW +: AW] = d;
        src_data[c*DW +: DW] = v;
    endtask

    initial begin
        // reset state
        model_reset();
        #12;
        check_all();
        for (int m = 0; m < 2; m++) begin
            chk("rst.wb_dest", 64'(dest_o[m]), 64'd0);
            chk("rst.wb_data", 64'(data_o[m]), 64'd0);
            chk("rst.wb_ch", 64'(ch_o[m]), 64'd0);
            chk("rst.src_ready", 64'(rdy_o[m]), 64'h7);
        end
        reset = 1'b1;

        // collision: three channels push twice in a row
        got.delete();
        put(0, 1, $urandom); put(1, 2, $urandom); put(2, 3, $urandom);
        step();
        put(0, 4, $urandom); put(1, 5, $urandom); put(2, 6, $urandom);
        step();
        if (vld_o[0]) got.push_back(dest_o[0]);
        src_valid = '0;
        repeat (6) begin
            step();
            if (vld_o[0]) got.push_back(dest_o[0]);
        end
        chk("coll.count", 64'(got.size()), 64'd6);
        for (int j = 0; j < got.size() && j < 6; j++)
            chk($sformatf("coll.dest%0d", j), 64'(got[j]), 64'(j + 1));
        chk("coll.overflow", 64'(ovf_o[0]), 64'd0);

        // single push on ch1
        put(1, 7, 32'hDEADBEEF);
        step();
        chk("single.early", 64'(vld_o[0]), 64'd0);
        src_valid = '0;
        step();
        chk("single.valid", 64'(vld_o[0]), 64'd1);
        chk("single.dest", 64'(dest_o[0]), 64'd7);
        chk("single.data", 64'(data_o[0]), 64'hDEADBEEF);
        chk("single.ch", 64'(ch_o[0]), 64'd1);
        step();
        chk("single.once", 64'(vld_o[0]), 64'd0);

        // fixed priority: ch0 streams while ch2 waits
        got.delete();
        put(0, 10, $urandom); put(2, 9, $urandom);
        step();
        if (vld_o[1]) got.push_back(dest_o[1]);
        for (int j = 1; j < 8; j++) begin
            src_valid = '0;
            put(0, AW'(10 + j), $urandom);
            step();
            if (vld_o[1]) got.push_back(dest_o[1]);
        end
        src_valid = '0;
        repeat (4) begin
            step();
            if (vld_o[1]) got.push_back(dest_o[1]);
        end
        chk("fp.count", 64'(got.size()), 64'd9);
        for (int j = 0; j < got.size() && j < 9; j++)
            chk($sformatf("fp.dest%0d", j), 64'(got[j]),
                (j < 8) ? 64'(10 + j) : 64'd9);
        repeat (8) step();
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;

        // backpressure and overflow
        wb_ready = 1'b0;
        for (int j = 0; j < 6; j++) begin
            src_valid = '0;
            put(0, AW'(20 + j), $urandom);
            step();
        end
        src_valid = '0;
        chk("bp.occ0", 64'(occ_o[0][OW-1:0]), 64'd4);
        chk("bp.rdy0", 64'(rdy_o[0][0]), 64'd0);
        chk("bp.ovf0", 64'(ovf_o[0][0]), 64'd1);
        chk("bp.hold", 64'(dest_o[0]), 64'd20);
        step();
        chk("bp.hold2", 64'(dest_o[0]), 64'd20);
        wb_ready = 1'b1;
        got.delete();
        repeat (6) begin
            step();
            if (vld_o[0]) got.push_back(dest_o[0]);
        end
        chk("bp.count", 64'(got.size()), 64'd4);
        for (int j = 0; j < got.size() && j < 4; j++)
            chk($sformatf("bp.dest%0d", j), 64'(got[j]), 64'(21 + j));
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("bp.clr", 64'(ovf_o[0][0]), 64'd0);

        // r0 discard
        put(1, 0, $urandom);
        step();
        src_valid = '0;
        step();
        chk("r0.valid", 64'(vld_o[0]), 64'd0);
        chk("r0.occ", 64'(occ_o[0]), 64'd0);

        // push and pop on a full FIFO in the same cycle
        wb_ready = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            src_valid = '0;
            put(0, AW'(j), $urandom);
            step();
        end
        chk("full.occ", 64'(occ_o[0][OW-1:0]), 64'd4);
        wb_ready = 1'b1;
        src_valid = '0;
        put(0, 6, $urandom);
        step();
        src_valid = '0;
        chk("full.occ_keep", 64'(occ_o[0][OW-1:0]), 64'd4);
        chk("full.no_ovf", 64'(ovf_o[0][0]), 64'd0);
        repeat (7) step();

        // asynchronous reset mid-stream
        wb_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            put(0, AW'($urandom_range(1, 31)), $urandom);
            put(1, AW'($urandom_range(1, 31)), $urandom);
            put(2, AW'($urandom_range(1, 31)), $urandom);
            step();
        end
        src_valid = '0;
        #2 reset = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("arst.valid", 64'(vld_o[m]), 64'd0);
            chk("arst.occ", 64'(occ_o[m]), 64'd0);
        end
        model_reset();
        check_all();
        wb_ready = 1'b1;
        #3 reset = 1'b1;
        put(0, 3, $urandom); put(2, 4, $urandom);
        step();
        src_valid = '0;
        step();
        for (int m = 0; m < 2; m++) begin
            chk("arst.first_valid", 64'(vld_o[m]), 64'd1);
            chk("arst.first_ch", 64'(ch_o[m]), 64'd0);
        end

        // randomized traffic
        repeat (300) begin
            for (int c = 0; c < N; c++) begin
                src_valid[c] = ($urandom_range(0, 2) != 0);
                src_dest[c*AW +: AW] = ($urandom_range(0, 7) == 0) ?
                    AW'(0) : AW'($urandom_range(1, 31));
                src_data[c*DW +: DW] = $urandom;
            end
            wb_ready = ($urandom_range(0, 3) != 0);
            overflow_clr = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
